counter_ctrl_fsm: RTL



---
 rtl/counter_ctrl_pkg.sv | 20 ++
 rtl/counter_ctrl_fsm_term_det.sv | 24 ++
 rtl/counter_ctrl_fsm.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types for the counter control sequencer.
//   state_e  : sequencer state encoding (IDLE/LOAD/RUN/DONE)
//   DIR_UP   : direction code for counting up
//   DIR_DOWN : direction code for counting down
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_ctrl_fsm_term_det.sv
// -----------------------------------------------------------------------------
// count_terminal_det
// Combinational terminal-count detector for an up/down counter.
// Ports:
//   count_i : current counter value
//   dir_i   : counting direction (DIR_UP / DIR_DOWN)
//   term_o  : high when count_i is the last value before a wrap
//             (all-ones when counting up, zero when counting down)
// -----------------------------------------------------------------------------
module count_terminal_det
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    output logic             term_o
);

    always_comb begin
        term_o = (dir_i == DIR_UP) ? (&count_i) : (~|count_i);
    end

endmodule

// File: rtl/counter_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// counter_ctrl_fsm
// Sequencer that runs an up/down counter for a programmed number of full laps.
// A job loads start_val, counts in the captured direction, counts terminal
// wraps and stops with a one-cycle done pulse after num_wraps wraps.
//
// Optional build macro: CTRL_AUTO_RELOAD_EN
//   defined   : DONE goes back to LOAD with the same captured settings, so the
//               job repeats until abort or reset.
//   undefined : DONE always returns to IDLE.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : job request, sampled only in IDLE
//   abort_i        : cancels a job in LOAD or RUN
//   dir_sel_i      : job direction (1=up, 0=down)
//   start_val_i    : value loaded into the counter at job start
//   num_wraps_i    : number of wraps before done
//   count_i        : counter's current value
//   load_o         : counter load strobe
//   enable_o       : counter enable
//   up_down_o      : counter direction (captured)
//   data_out_o     : counter load data (captured start_val)
//   busy_o         : high in LOAD and RUN
//   done_o         : one-cycle pulse at job completion
//   wrap_cnt_o     : wraps completed in the current or last job
//   state_dbg_o    : current sequencer state, for observation
//
// Handshake: start_i is a level request; it is taken only on an edge where the
// sequencer is IDLE and is ignored at all other times. All outputs are a pure
// decode of registers, so nothing on the inputs reaches an output in the same
// cycle.
// -----------------------------------------------------------------------------
module counter_ctrl_fsm
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dir_sel_i,
    input  logic [WIDTH-1:0] start_val_i,
    input  logic [CYC_W-1:0] num_wraps_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             load_o,
    output logic             enable_o,
    output logic             up_down_o,
    output logic [WIDTH-1:0] data_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CYC_W-1:0] wrap_cnt_o,
    output state_e           state_dbg_o
);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [CYC_W-1:0]   nw_q, nw_d;
    logic [CYC_W-1:0]   wrap_q, wrap_d;
    logic               term;
    logic [CYC_W:0]     wrap_inc;

    count_terminal_det #(
        .WIDTH (WIDTH)
    ) u_term_det (
        .count_i (count_i),
        .dir_i   (dir_q),
        .term_o  (term)
    );

    // One bit wider so the completion compare cannot alias on overflow.
    assign wrap_inc = {1'b0, wrap_q} + {{CYC_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            val_q   <= '0;
            nw_q    <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            val_q   <= val_d;
            nw_q    <= nw_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        val_d   = val_q;
        nw_d    = nw_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dir_d   = dir_sel_i;
                    val_d   = start_val_i;
                    nw_d    = num_wraps_i;
                    wrap_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (nw_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort wins over a wrap on the same edge; wrap_cnt is held.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (term) begin
                    if (wrap_q != {CYC_W{1'b1}}) begin
                        wrap_d = wrap_inc[CYC_W-1:0];
                    end
                    if (wrap_inc == {1'b0, nw_q}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
`ifdef CTRL_AUTO_RELOAD_EN
                wrap_d  = '0;
                state_d = LOAD;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore decode from registered state only.
    always_comb begin
        load_o      = (state_q == LOAD);
        enable_o    = (state_q == RUN);
        busy_o      = (state_q == LOAD) || (state_q == RUN);
        done_o      = (state_q == DONE);
        up_down_o   = dir_q;
        data_out_o  = val_q;
        wrap_cnt_o  = wrap_q;
        state_dbg_o = state_q;
    end

endmodule
